// File: rtl/clk_monitor.sv
// clk_monitor: synchronizes a slow asynchronous signal, emits edge pulses,
// measures the rise-to-rise period in clk cycles and flags loss of activity.
// Optional glitch filter on the synchronized level: CLK_MONITOR_GLITCH_FILTER_EN.
module clk_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             lost,
   output logic [1:0]       state
);

   // Last count value before the loss timeout fires (cnt + 1 == TIMEOUT)
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOST    = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d_q;
   logic                   rise_c;
   logic                   fall_c;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       period_q;
   logic                   period_valid_q;
   logic                   lost_q;
   logic                   rise_pulse_q;
   logic                   fall_pulse_q;

   // Multi-flop synchronizer for the asynchronous input
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

`ifdef CLK_MONITOR_GLITCH_FILTER_EN
   logic s_q;

   // Accept a new level only once it is present in the last two stages
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
         s_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s = s_q;
`else
   assign s = sync_q[SYNC_STAGES-1];
`endif

   // Delayed copy of the synchronized level for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s_d_q <= 1'b0;
      end else begin
         s_d_q <= s;
      end
   end

   assign rise_c = s & ~s_d_q;
   assign fall_c = ~s & s_d_q;

   // Monitor FSM: edge pulses, period counter, loss detection
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         lost_q         <= 1'b0;
         rise_pulse_q   <= 1'b0;
         fall_pulse_q   <= 1'b0;
      end else begin
         rise_pulse_q   <= rise_c;
         fall_pulse_q   <= fall_c;
         period_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_MEASURE: begin
               if (rise_c) begin
                  // First rise after idle only arms the measurement
                  if (state_q == ST_MEASURE) begin
                     period_q       <= cnt_q + CNT_W'(1);
                     period_valid_q <= 1'b1;
                  end
                  state_q <= ST_MEASURE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_LOST;
                  lost_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_LOST: begin
               cnt_q <= '0;
               // Re-acquisition: restart measuring, no period reported
               if (rise_c) begin
                  state_q <= ST_MEASURE;
                  lost_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               lost_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rise_pulse   = rise_pulse_q;
   assign fall_pulse   = fall_pulse_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign lost         = lost_q;
   assign state        = state_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed and randomized checks of clk_monitor against a
// cycle-level reference model built from delay-line and interval arithmetic.
module tb_clk_monitor;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned TMO   = 100;
`ifdef CLK_MONITOR_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   localparam int LAT = SYNC + 1 + FILT;

   logic             clk;
   logic             rst;
   logic             sig_in;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             lost;
   logic [1:0]       state;

   clk_monitor #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC),
      .TIMEOUT     (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sig_in       (sig_in),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .period       (period),
      .period_valid (period_valid),
      .lost         (lost),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
      end
   endtask

   // Reference model: samples of sig_in (hist[0] newest), synchronized level
   // history, and the monitor's behaviour in terms of rise timestamps.
   logic [7:0] hist;
   bit  f1, f2;            // synchronized level one and two cycles ago
   int  m_mode;            // 0 idle, 1 measuring, 2 lost
   int  m_ref;             // cycle of last rise/reset; counting starts after it
   int  m_period;
   bit  m_rise, m_fall, m_pv, m_lost;

   task automatic model_edge(input bit r, input bit x);
      bit rise, fall, fnew;
      if (r) begin
         hist = '0; f1 = 0; f2 = 0;
         m_mode = 0; m_ref = cyc; m_period = 0;
         m_rise = 0; m_fall = 0; m_pv = 0; m_lost = 0;
      end else begin
         rise = f1 && !f2;
         fall = !f1 && f2;
         hist = {hist[6:0], x};
         if (FILT != 0) fnew = (hist[SYNC-1] == hist[SYNC]) ? hist[SYNC-1] : f1;
         else           fnew = hist[SYNC-1];
         f2 = f1; f1 = fnew;
         m_rise = rise; m_fall = fall; m_pv = 0;
         if (rise) begin
            if (m_mode == 1) begin
               m_pv = 1;
               m_period = cyc - m_ref;
            end
            m_mode = 1; m_ref = cyc; m_lost = 0;
         end else if (m_mode != 2 && (cyc - m_ref) == int'(TMO)) begin
            m_mode = 2; m_lost = 1;
         end
      end
   endtask

   // Observations of rise pulses and expected edge latencies
   int rp_cyc[$];
   int rp_pv[$];
   int rp_per[$];
   int rp_lost[$];
   int rise_exp_q[$];
   int fall_exp_q[$];
   int n_rise = 0;
   int n_fall = 0;
   bit lat_en = 0;

   task automatic step();
      logic [31:0] got, exp;
      @(posedge clk);
      cyc++;
      model_edge(rst, sig_in);
      @(negedge clk);
      got = 32'({rise_pulse, fall_pulse, period_valid, lost, state, period});
      exp = 32'({m_rise, m_fall, m_pv, m_lost, 2'(m_mode), 8'(m_period)});
      chk("cycle_outputs", got, exp);
      if (rise_pulse) begin
         n_rise++;
         rp_cyc.push_back(cyc);
         rp_pv.push_back(int'(period_valid));
         rp_per.push_back(int'(period));
         rp_lost.push_back(int'(lost));
         if (rise_exp_q.size() > 0) chk("rise_latency", cyc, rise_exp_q.pop_front());
      end
      if (fall_pulse) begin
         n_fall++;
         if (fall_exp_q.size() > 0) chk("fall_latency", cyc, fall_exp_q.pop_front());
      end
   endtask

   task automatic clear_obs();
      rp_cyc.delete(); rp_pv.delete(); rp_per.delete(); rp_lost.delete();
   endtask

   // Square wave, period 8: 4 cycles high then 4 low
   task automatic wave(input int nper);
      for (int p = 0; p < nper; p++) begin
         sig_in = 1'b1;
         if (lat_en) rise_exp_q.push_back(cyc + LAT);
         repeat (4) step();
         sig_in = 1'b0;
         if (lat_en) fall_exp_q.push_back(cyc + LAT);
         repeat (4) step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int last_rise;
      int lvl, len;

      hist = '0; f1 = 0; f2 = 0;
      m_mode = 0; m_ref = 0; m_period = 0;
      m_rise = 0; m_fall = 0; m_pv = 0; m_lost = 0;
      rst = 1'b1;
      sig_in = 1'b0;

      // Reset with input low
      repeat (3) step();
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outputs", 32'({rise_pulse, fall_pulse, period_valid, lost, period}), 32'd0);
      rst = 1'b0;

      // Lock onto an 8-cycle wave
      clear_obs();
      lat_en = 1;
      wave(5);
      chk("lock_rise_count", rp_cyc.size(), 5);
      chk("lock_first_pv", rp_pv[0], 0);
      chk("lock_second_pv", rp_pv[1], 1);
      chk("lock_second_period", rp_per[1], 8);
      chk("lock_rise_spacing", rp_cyc[4] - rp_cyc[3], 8);
      last_rise = rp_cyc[rp_cyc.size() - 1];

      // Hold low until loss is declared
      sig_in = 1'b0;
      k = 0;
      while (!lost && k < 200) begin
         step();
         k++;
      end
      chk("lost_seen", 32'(lost), 32'd1);
      chk("lost_delay", cyc - last_rise, 100);
      chk("lost_state", 32'(state), 32'd2);
      chk("lost_period_held", 32'(period), 32'd8);

      // Re-acquire from loss
      clear_obs();
      wave(3);
      chk("reacq_lost_clear", rp_lost[0], 0);
      chk("reacq_first_pv", rp_pv[0], 0);
      chk("reacq_second_pv", rp_pv[1], 1);
      chk("reacq_second_period", rp_per[1], 8);

      // Single-cycle high pulse
      lat_en = 0;
      repeat (4) step();
      n_rise = 0;
      n_fall = 0;
      sig_in = 1'b1;
      step();
      sig_in = 1'b0;
      repeat (10) step();
      chk("glitch_rise_count", n_rise, (FILT != 0) ? 0 : 1);
      chk("glitch_fall_count", n_fall, (FILT != 0) ? 0 : 1);

      // Reset in the middle of a measurement (cnt = 5)
      sig_in = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (!rise_pulse && k < 20);
      chk("mid_rise_seen", 32'(rise_pulse), 32'd1);
      repeat (5) step();
      rst = 1'b1;
      sig_in = 1'b0;
      step();
      chk("mid_rst_pv", 32'(period_valid), 32'd0);
      chk("mid_rst_period", 32'(period), 32'd0);
      chk("mid_rst_state", 32'(state), 32'd0);
      rst = 1'b0;
      clear_obs();
      lat_en = 1;
      wave(3);
      chk("post_rst_first_pv", rp_pv[0], 0);
      chk("post_rst_second_pv", rp_pv[1], 1);
      chk("post_rst_period", rp_per[1], 8);
      chk("rise_latency_pending", rise_exp_q.size(), 0);
      chk("fall_latency_pending", fall_exp_q.size(), 0);

      // Randomized segments, including long idle stretches and resets
      lat_en = 0;
      for (int seg = 0; seg < 80; seg++) begin
         lvl = int'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) len = int'($urandom_range(95, 130));
         else                           len = int'($urandom_range(1, 12));
         sig_in = lvl[0];
         repeat (len) step();
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
